piezo_note_scheduler: RTL and testbench
=======================================

# piezo_note_scheduler

Schedules notes onto the shared piezo tone divider for the launchpad. Eight pad requesters raise note requests. The block arbitrates round-robin and configures the divider's half-period limit. It enables the divider for a fixed note duration, then inserts a silent gap before the next note. It sits between the pad/key-scan logic and the piezo divider, which is the only device that drives the buzzer pin.

## Interface
Parameters:
- NREQ, 8, number of pad requesters; also the number of entries in the note table
- LIMIT_W, 16, width of the divider half-period limit
- DUR_W, 24, width of the duration counters
- NOTE_DUR, 500000, cycles DIV_EN stays high per note; must be ≥1
- GAP_DUR, 50000, silent cycles after each note; may be 0

Ports:
- CLK  in  1  system clock; all logic on the rising edge
- RST  in  1  asynchronous, active-low reset
- EN  in  1  global play enable
- REQ  in  NREQ  pad request levels; one note is requested per rising edge
- GNT  out  NREQ  one-hot, one-cycle pulse marking the pad granted
- CUR_IDX  out  $clog2(NREQ)  index of the current or last granted pad
- DIV_EN  out  1  enable to the piezo divider
- DIV_LIMIT  out  LIMIT_W  half-period count for the divider, taken from NOTE_LIMIT[CUR_IDX]
- BUSY  out  1  high in PLAY and GAP

## Operation
- Edge detect: REQ is registered each cycle. A 0→1 transition on bit i sets pend[i].
  - A held pad produces exactly one note.
- pend[i] clears on the cycle pad i is granted.
  - If a new rising edge on the same bit arrives in that same cycle, the set wins and the note is re-queued.
- FSM states IDLE, PLAY, GAP:
  - IDLE: if EN=1 and pend≠0, grant round-robin. The search starts at last+1 and wraps from NREQ-1 to 0.
    - The grant sets GNT, CUR_IDX, DIV_LIMIT and DIV_EN=1, updates last, loads cnt=NOTE_DUR-1, and moves to PLAY.
  - PLAY: decrement cnt. At cnt=0:
    - DIV_EN goes to 0.
    - If GAP_DUR>0: load cnt=GAP_DUR-1 and go to GAP.
    - Otherwise go to IDLE.
  - GAP: decrement cnt. At cnt=0 go to IDLE.
- EN=0 in PLAY or GAP: abort to IDLE on the next edge with DIV_EN=0. pend is kept, and the aborted note is not re-queued.
- EN=0 in IDLE: no grants, but pend keeps accumulating.
- DIV_LIMIT and CUR_IDX hold their last value outside PLAY, so the divider never sees a glitch.
- Reset, asynchronous on RST=0: all outputs 0, pend=0, REQ register=0, state IDLE, last=NREQ-1 so pad 0 has first priority. Reset mid-note kills DIV_EN immediately.

## Timing
- All outputs are registered.
- Request latency: a REQ[i] rise sampled at edge k sets pend at k+1. With the FSM in IDLE and EN=1, GNT, DIV_EN and DIV_LIMIT change at edge k+2.
- DIV_EN stays high for exactly NOTE_DUR cycles, then low for GAP_DUR cycles.
- IDLE lasts at least 1 cycle between notes. Back-to-back notes therefore start every NOTE_DUR+GAP_DUR+1 cycles.
- GNT is high for one cycle, aligned with the first DIV_EN=1 cycle.
- Simultaneous requests resolve in round-robin order, one grant per note slot. No request is lost, and each pad has at most one pending note.

## Structure
- Package piezo_pkg:
  - NOTE_LIMIT[0:7] table for a 1 MHz CLK (C4..C5): 1911, 1703, 1517, 1432, 1276, 1136, 1012, 956
  - state enum {IDLE, PLAY, GAP}
- Sub-module rr_arbiter (NREQ): inputs req vector and last index; outputs one-hot grant, index and valid. Purely combinational and reused by other shared-resource controllers.
- The top level holds the edge detect, pend register, FSM and duration counter.

## Test plan
All scenarios use NOTE_DUR=8, GAP_DUR=2.
- Reset: RST=0 with REQ toggling → all outputs 0, no GNT. Release RST with EN=1 and pulse REQ[3] → GNT=8'h08 two edges later, DIV_LIMIT=1432, DIV_EN high for 8 cycles, BUSY high for 10.
- Held pad: REQ[5] held high for 40 cycles → exactly one note, DIV_LIMIT=1136.
- Simultaneous requests: REQ=8'hFF rising from reset → grants in order 0,1,…,7, each DIV_EN window 8 cycles, note starts 11 cycles apart.
- Round-robin fairness: last grant=6, then pend={1,7} → pad 7 granted first, then pad 1.
- Abort: EN drops 3 cycles into a note → DIV_EN=0 next edge, FSM in IDLE, other pend bits preserved. EN returns → next pending pad is played.
- GAP_DUR=0 variant: REQ=8'h03 → pad 0 and pad 1 notes start 9 cycles apart.

Source files
------------

// File: rtl/piezo_pkg.sv
// Shared types and the note pitch table for the piezo note scheduler.
// The table is tuned for a 1 MHz system clock, spanning C4 to C5.
package piezo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } piezo_state_e;

  localparam int NOTE_TAB_N = 8;

  // Divider half-period counts, indexed by pad number.
  localparam logic [15:0] NOTE_LIMIT [0:NOTE_TAB_N-1] = '{
    16'd1911, 16'd1703, 16'd1517, 16'd1432,
    16'd1276, 16'd1136, 16'd1012, 16'd956
  };

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search starts one past the last winner
// and wraps, so the most recent winner has the lowest priority.
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] sel;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sel     = '0;
    for (int k = 1; k <= N; k++) begin
      sel = IW'((int'(last_i) + k) % N);
      if (!valid_o && req_i[sel]) begin
        valid_o    = 1'b1;
        idx_o      = sel;
        gnt_o[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/piezo_note_scheduler.sv
// Arbitrates pad note requests onto the single piezo divider: one fixed-length
// note per grant followed by a silent gap. Handshake: none; requests are edges.
module piezo_note_scheduler
  import piezo_pkg::*;
#(
  parameter int NREQ     = 8,
  parameter int LIMIT_W  = 16,
  parameter int DUR_W    = 24,
  parameter int NOTE_DUR = 500000,
  parameter int GAP_DUR  = 50000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN,
  input  logic [NREQ-1:0]         REQ,
  output logic [NREQ-1:0]         GNT,
  output logic [$clog2(NREQ)-1:0] CUR_IDX,
  output logic                    DIV_EN,
  output logic [LIMIT_W-1:0]      DIV_LIMIT,
  output logic                    BUSY,
  output logic [1:0]              DBG_STATE
);

  localparam int IW = $clog2(NREQ);
  localparam logic [DUR_W-1:0] NOTE_LOAD = DUR_W'(NOTE_DUR - 1);
  localparam logic [DUR_W-1:0] GAP_LOAD  = (GAP_DUR > 0) ? DUR_W'(GAP_DUR - 1) : '0;

  logic [NREQ-1:0]    req_q, req_prev_q, rise;
  logic [NREQ-1:0]    pend_q, pend_d, clr;
  logic [NREQ-1:0]    arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;
  piezo_state_e       state_q, state_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]      last_q, last_d, idx_q, idx_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               div_en_q, div_en_d, busy_q, busy_d;
  logic [LIMIT_W-1:0] limit_q, limit_d;

  // Two-stage sampling so a rise sampled at one edge sets pend on the next.
  assign rise = req_q & ~req_prev_q;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .req_i   (pend_q),
    .last_i  (last_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    idx_d    = idx_q;
    limit_d  = limit_q;
    div_en_d = div_en_q;
    gnt_d    = '0;
    clr      = '0;
    case (state_q)
      IDLE: begin
        if (EN && arb_valid) begin
          clr      = arb_gnt;
          gnt_d    = arb_gnt;
          idx_d    = arb_idx;
          last_d   = arb_idx;
          limit_d  = LIMIT_W'(NOTE_LIMIT[arb_idx]);
          div_en_d = 1'b1;
          cnt_d    = NOTE_LOAD;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (!EN) begin
          div_en_d = 1'b0;
          state_d  = IDLE;
        end else if (cnt_q == '0) begin
          div_en_d = 1'b0;
          if (GAP_DUR > 0) begin
            cnt_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (!EN || cnt_q == '0) state_d = IDLE;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        div_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    // A fresh rise in the grant cycle wins over the clear and re-queues the pad.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      req_q      <= '0;
      req_prev_q <= '0;
      pend_q     <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= IW'(NREQ - 1);
      idx_q      <= '0;
      gnt_q      <= '0;
      div_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      limit_q    <= '0;
    end else begin
      req_q      <= REQ;
      req_prev_q <= req_q;
      pend_q     <= pend_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      gnt_q      <= gnt_d;
      div_en_q   <= div_en_d;
      busy_q     <= busy_d;
      limit_q    <= limit_d;
    end
  end

  assign GNT       = gnt_q;
  assign CUR_IDX   = idx_q;
  assign DIV_EN    = div_en_q;
  assign DIV_LIMIT = limit_q;
  assign BUSY      = busy_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_piezo_note_scheduler.sv
// Directed bench for piezo_note_scheduler: grant order, latency, note/gap
// lengths, abort and reset behaviour, plus a zero-gap instance.
module tb_piezo_note_scheduler;

  localparam int NOTE_DUR = 8;
  localparam int GAP_DUR  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, en0;
  logic [7:0]  req, req0;
  logic [7:0]  gnt, gnt0;
  logic [2:0]  cur_idx, cur_idx0;
  logic        div_en, div_en0, busy, busy0;
  logic [15:0] div_limit, div_limit0;
  logic [1:0]  dbg_state, dbg_state0;

  piezo_note_scheduler #(
    .NREQ(8), .LIMIT_W(16), .DUR_W(24), .NOTE_DUR(NOTE_DUR), .GAP_DUR(GAP_DUR)
  ) dut (
    .CLK(clk), .RST(rst_n), .EN(en), .REQ(req), .GNT(gnt), .CUR_IDX(cur_idx),
    .DIV_EN(div_en), .DIV_LIMIT(div_limit), .BUSY(busy), .DBG_STATE(dbg_state)
  );

  piezo_note_scheduler #(
    .NREQ(8), .LIMIT_W(16), .DUR_W(24), .NOTE_DUR(NOTE_DUR), .GAP_DUR(0)
  ) dut0 (
    .CLK(clk), .RST(rst_n), .EN(en0), .REQ(req0), .GNT(gnt0), .CUR_IDX(cur_idx0),
    .DIV_EN(div_en0), .DIV_LIMIT(div_limit0), .BUSY(busy0), .DBG_STATE(dbg_state0)
  );

  int lim_tab [8] = '{1911, 1703, 1517, 1432, 1276, 1136, 1012, 956};

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp0_q [$];

  int   cyc = 0;
  int   n_grants = 0;
  logic chk_len, chk_space;
  logic en_prev, busy_prev, en0_prev, have_prev, have_prev0;
  int   en_rise, busy_rise, en0_rise, prev_start, prev0_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of observation on the falling edge; scoreboards both instances.
  task automatic cyc_step();
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      en_prev = 1'b0; busy_prev = 1'b0; en0_prev = 1'b0;
      have_prev = 1'b0; have_prev0 = 1'b0;
      return;
    end
    if (div_en && !en_prev) en_rise = cyc;
    if (!div_en && en_prev && chk_len) check("note_len", 32'(cyc - en_rise), NOTE_DUR);
    if (busy && !busy_prev) busy_rise = cyc;
    if (!busy && busy_prev && chk_len) check("busy_len", 32'(cyc - busy_rise), NOTE_DUR + GAP_DUR);
    if (gnt != '0) begin
      if (exp_q.size() == 0) begin
        check("spurious_gnt", 32'(gnt), 0);
      end else begin
        e = exp_q.pop_front();
        check("gnt", 32'(gnt), 32'(1) << e);
        check("cur_idx", 32'(cur_idx), e);
        check("div_limit", 32'(div_limit), 32'(lim_tab[e]));
        check("div_en_at_gnt", 32'(div_en), 1);
        if (chk_space && have_prev)
          check("start_spacing", 32'(cyc - prev_start), NOTE_DUR + GAP_DUR + 1);
        prev_start = cyc;
        have_prev  = 1'b1;
        n_grants++;
      end
    end
    if (!chk_space) have_prev = 1'b0;
    if (div_en0 && !en0_prev) en0_rise = cyc;
    if (!div_en0 && en0_prev) check("gap0_note_len", 32'(cyc - en0_rise), NOTE_DUR);
    if (gnt0 != '0) begin
      if (exp0_q.size() == 0) begin
        check("gap0_spurious_gnt", 32'(gnt0), 0);
      end else begin
        e = exp0_q.pop_front();
        check("gap0_gnt", 32'(gnt0), 32'(1) << e);
        check("gap0_limit", 32'(div_limit0), 32'(lim_tab[e]));
        if (have_prev0) check("gap0_spacing", 32'(cyc - prev0_start), NOTE_DUR + 1);
        prev0_start = cyc;
        have_prev0  = 1'b1;
      end
    end
    en_prev   = div_en;
    busy_prev = busy;
    en0_prev  = div_en0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy || exp0_q.size() != 0 || busy0) && n < max) begin
      cyc_step();
      n++;
    end
    check("drain_left", 32'(exp_q.size() + exp0_q.size()), 0);
    cyc_step();
    cyc_step();
  endtask

  task automatic wait_gnt(input int max);
    int   n    = 0;
    logic seen = 1'b0;
    while (!seen && n < max) begin
      cyc_step();
      n++;
      if (gnt != '0) seen = 1'b1;
    end
    check("gnt_seen", 32'(seen), 1);
  endtask

  initial begin
    int g0;
    rst_n = 1'b0; en = 1'b0; en0 = 1'b0; req = '0; req0 = '0;
    chk_len = 1'b0; chk_space = 1'b0;
    en_prev = 1'b0; busy_prev = 1'b0; en0_prev = 1'b0;
    have_prev = 1'b0; have_prev0 = 1'b0;
    en_rise = 0; busy_rise = 0; en0_rise = 0; prev_start = 0; prev0_start = 0;

    // Reset held with REQ toggling
    for (int i = 0; i < 4; i++) begin
      req = 8'($urandom_range(0, 255));
      cyc_step();
      check("rst_gnt", 32'(gnt), 0);
      check("rst_outs", 32'({div_en, busy, cur_idx, div_limit}), 0);
    end
    req = '0;
    cyc_step();
    rst_n = 1'b1; en = 1'b1;
    cyc_step();
    cyc_step();

    // Single pulse on pad 3: grant two edges after the sampling edge
    chk_len = 1'b1;
    exp_q.push_back(3);
    req = 8'h08;
    cyc_step();
    req = '0;
    cyc_step();
    check("lat_early_gnt", 32'(gnt), 0);
    cyc_step();
    check("lat_gnt", 32'(gnt), 32'h08);
    check("lat_limit", 32'(div_limit), 1432);
    drain(40);

    // Held pad 5 yields exactly one note
    g0 = n_grants;
    exp_q.push_back(5);
    req = 8'h20;
    repeat (40) cyc_step();
    req = '0;
    drain(40);
    check("held_one_note", 32'(n_grants - g0), 1);

    // All pads rising together right after reset
    rst_n = 1'b0;
    cyc_step();
    rst_n = 1'b1;
    cyc_step();
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    chk_space = 1'b1;
    g0 = n_grants;
    req = 8'hFF;
    drain(150);
    chk_space = 1'b0;
    req = '0;
    cyc_step();
    check("sim_count", 32'(n_grants - g0), 8);

    // Fairness: last winner 6, then pads 1 and 7 together
    exp_q.push_back(6);
    req = 8'h40;
    cyc_step();
    req = '0;
    drain(40);
    exp_q.push_back(7);
    exp_q.push_back(1);
    req = 8'h82;
    cyc_step();
    req = '0;
    drain(60);

    // Abort a note with EN low; pad 4 stays pending, pad 2 is not replayed
    chk_len = 1'b0;
    exp_q.push_back(2);
    req = 8'h14;
    cyc_step();
    req = '0;
    wait_gnt(20);
    repeat (3) cyc_step();
    en = 1'b0;
    cyc_step();
    check("abort_div_en", 32'(div_en), 0);
    check("abort_state", 32'(dbg_state), 0);
    check("abort_busy", 32'(busy), 0);
    repeat (5) cyc_step();
    check("abort_stay_idle", 32'(busy), 0);
    check("abort_limit_hold", 32'(div_limit), 1517);
    en = 1'b1;
    chk_len = 1'b1;
    exp_q.push_back(4);
    drain(40);

    // Reset mid-note drops DIV_EN without waiting for a clock
    exp_q.push_back(0);
    req = 8'h01;
    cyc_step();
    req = '0;
    wait_gnt(20);
    cyc_step();
    rst_n = 1'b0;
    #1;
    check("rst_mid_div_en", 32'(div_en), 0);
    check("rst_mid_busy", 32'(busy), 0);
    cyc_step();
    rst_n = 1'b1;
    cyc_step();

    // Zero-gap instance: pads 0 and 1 start NOTE_DUR+1 apart
    en0 = 1'b1;
    cyc_step();
    exp0_q.push_back(0);
    exp0_q.push_back(1);
    req0 = 8'h03;
    cyc_step();
    req0 = '0;
    drain(60);
    check("gap0_both_played", 32'(have_prev0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
